guvm_data_mem_responder: RTL and testbench
==========================================

// Module: guvm_data_mem_responder
// PURPOSE
//  Memory-side responder for the core's data memory port: consumes data_req/addr/we/be/wdata, returns gnt, rvalid, rdata.
//  Replaces the tied-high gnt/rvalid stubs in the GUVM bench with a real req/gnt/rvalid handshake.
//  Adds programmable grant stalls, a fixed response latency, bounded outstanding transactions and a write strobe for the scoreboard.
// PARAMETERS
//  MEM_WORDS        256  32-bit words of backing store; power of 2.
//  RESP_LATENCY     1    cycles from accept edge to rvalid; legal 1..4.
//  MAX_OUTSTANDING  2    accepted-but-unresponded limit; legal 1..4.
// PORTS
//  clk_i           in   1   clock
//  rst_ni          in   1   asynchronous reset, active low
//  data_req_i      in   1   core request
//  data_gnt_o      out  1   grant; accept = req & gnt at posedge
//  data_addr_i     in   32  byte address; word index = addr[2 +: log2(MEM_WORDS)]
//  data_we_i       in   1   1 = write, 0 = read
//  data_be_i       in   4   byte enables; bit n = data[8n+7:8n]
//  data_wdata_i    in   32  write data
//  data_rvalid_o   out  1   response valid, one cycle per accepted transaction
//  data_rdata_o    out  32  read data; 0 for writes and errors
//  data_err_o      out  1   qualified by rvalid; 1 = address out of range
//  stall_cfg_i     in   4   grant-stall cycles per request; 0 = grant immediately
//  wr_strobe_o     out  1   one-cycle pulse after every accepted in-range write
//  wr_addr_o       out  32  byte address of that write
//  wr_data_o       out  32  merged word after the byte-enable update
// BEHAVIOUR
//  Reset: all outputs 0; FSM goes to IDLE; stall counter, outstanding count and response pipe cleared; in-flight responses dropped.
//  Memory contents are not reset.
//  Grant FSM:
//   IDLE: req & stall_cfg==0 -> GRANT (gnt same cycle); req & stall_cfg!=0 -> STALL, cnt=stall_cfg.
//   STALL: gnt=0; cnt decrements each cycle; cnt reaches 1 -> GRANT; req drops -> IDLE.
//   GRANT: gnt = req & (outstanding < MAX_OUTSTANDING) (combinational). Accept -> IDLE. req drops -> IDLE.
//  Back-to-back requests: every accepted request incurs its own stall_cfg stall.
//  Accept edge:
//   In range (addr < MEM_WORDS*4): write updates only enabled byte lanes; read samples the pre-write word.
//   be==0 write is legal: no memory change, still responds, still pulses wr_strobe_o.
//   Out of range: no memory access; response carries err=1, rdata=0.
//   Address bits [1:0] are ignored.
//  Response pipe: RESP_LATENCY-stage shift of {valid, rdata, err}.
//   Accept at edge k -> rvalid high in the cycle after edge k+RESP_LATENCY-1, for exactly one cycle.
//   Responses return in accept order; no response without an accept.
//  Outstanding counter: +1 on accept, -1 on rvalid; simultaneous accept and rvalid leave it unchanged.
//   Never exceeds MAX_OUTSTANDING; gnt stays low while at the limit.
//  Writes also produce rvalid, with rdata=0.
//  wr_strobe_o/wr_addr_o/wr_data_o are registered and valid the cycle after the accept edge.
//  A read accepted on the edge after a write to the same word returns the written data (no hazard).
//  stall_cfg_i is sampled only in IDLE; a change mid-stall takes effect on the next request.
// TESTING
//  stall=0, LAT=1: write 0x100 be=F data=0xCAFEF00D, then read 0x100 -> gnt same cycle; rvalid 1 cycle later; rdata=0xCAFEF00D, err=0.
//  Partial write be=4'b0010 data=0x0000AB00 over 0x11223344 at 0x20 -> wr_data_o=0x1122AB44; read-back matches.
//  stall_cfg=3, req held -> gnt low 3 cycles, high on cycle 4; req dropped mid-stall -> no accept, no rvalid.
//  LAT=4, MAX=2, continuous reads -> at most 2 outstanding; gnt low at limit; 3rd accept on the rvalid cycle; responses in order.
//  Read 0x0000_0400 with MEM_WORDS=256 -> rvalid with err=1, rdata=0; no memory change.
//  rst_ni low with 2 responses in flight -> rvalid never asserts; outputs 0; first request after release is granted normally.

Source files
------------

// File: rtl/guvm_data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : guvm_data_mem_responder_if
// Brief    : Core data-memory port bundle (req/gnt/rvalid handshake).
// Revision : 1.0 - initial release
// ============================================================================
interface guvm_data_mem_responder_if;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    modport master (
        output data_req,
        output data_addr,
        output data_we,
        output data_be,
        output data_wdata,
        input  data_gnt,
        input  data_rvalid,
        input  data_rdata,
        input  data_err
    );

    modport slave (
        input  data_req,
        input  data_addr,
        input  data_we,
        input  data_be,
        input  data_wdata,
        output data_gnt,
        output data_rvalid,
        output data_rdata,
        output data_err
    );
endinterface
`default_nettype wire

// File: rtl/guvm_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : guvm_data_mem_responder
// Brief    : Memory-side responder for the core data port with grant stalls,
//            fixed response latency, bounded outstanding and a write strobe.
// Revision : 1.0 - initial release
// ============================================================================
module guvm_data_mem_responder #(
    parameter int MEM_WORDS       = 256,
    parameter int RESP_LATENCY    = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_ni,
    guvm_data_mem_responder_if.slave    data_if,
    input  wire logic [3:0]             stall_cfg_i,
    output logic                        wr_strobe_o,
    output logic [31:0]                 wr_addr_o,
    output logic [31:0]                 wr_data_o
);

    localparam int          c_AW  = $clog2(MEM_WORDS);
    localparam logic [2:0]  c_MAX = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             stall_cnt_q, stall_cnt_d;
    logic [2:0]             out_cnt_q, out_cnt_d;

    logic [31:0]            mem_q [MEM_WORDS];

    logic [RESP_LATENCY-1:0]        pv_q;
    logic [RESP_LATENCY-1:0][31:0]  pd_q;
    logic [RESP_LATENCY-1:0]        pe_q;

    logic                   wr_strobe_q;
    logic [31:0]            wr_addr_q;
    logic [31:0]            wr_data_q;

    logic                   w_gnt;
    logic                   w_room;
    logic                   w_accept;
    logic                   w_in_range;
    logic [c_AW-1:0]        w_idx;
    logic [31:0]            w_old;
    logic [31:0]            w_merged;
    logic                   w_mem_wr;
    logic [31:0]            w_resp_data;
    logic                   w_resp_err;
    logic                   w_rvalid;
    logic [2:0]             w_eff_out;

    assign w_rvalid   = pv_q[RESP_LATENCY-1];

    // The response leaving this cycle already counts as retired, so a new
    // request can be granted in the same cycle the limit frees up.
    assign w_eff_out  = out_cnt_q - {2'b00, w_rvalid};
    assign w_room     = (w_eff_out < c_MAX);

    assign w_in_range = (data_if.data_addr[31:2] < 30'(MEM_WORDS));
    assign w_idx      = data_if.data_addr[2 +: c_AW];
    assign w_old      = mem_q[w_idx];
    assign w_accept   = data_if.data_req & w_gnt;
    assign w_mem_wr   = w_accept & data_if.data_we & w_in_range;

    always_comb begin
        w_merged = w_old;
        for (int b = 0; b < 4; b++) begin
            if (data_if.data_be[b]) begin
                w_merged[8*b +: 8] = data_if.data_wdata[8*b +: 8];
            end
        end
    end

    assign w_resp_data = (w_accept & ~data_if.data_we & w_in_range) ? w_old : 32'h0;
    assign w_resp_err  = w_accept & ~w_in_range;

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        w_gnt       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (data_if.data_req) begin
                    if (stall_cfg_i == 4'd0) begin
                        w_gnt   = w_room;
                        state_d = w_room ? ST_IDLE : ST_GRANT;
                    end else if (stall_cfg_i == 4'd1) begin
                        // a one-cycle stall is the IDLE cycle itself
                        state_d = ST_GRANT;
                    end else begin
                        state_d     = ST_STALL;
                        stall_cnt_d = stall_cfg_i;
                    end
                end
            end
            ST_STALL: begin
                if (!data_if.data_req) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q - 4'd1;
                    if (stall_cnt_d == 4'd1) begin
                        state_d = ST_GRANT;
                    end
                end
            end
            ST_GRANT: begin
                if (!data_if.data_req) begin
                    state_d = ST_IDLE;
                end else begin
                    w_gnt = w_room;
                    if (w_room) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_cnt_d = out_cnt_q + {2'b00, w_accept} - {2'b00, w_rvalid};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= 4'd0;
            out_cnt_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    // Backing store is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_mem_wr) begin
            mem_q[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv_q <= '0;
            pd_q <= '0;
            pe_q <= '0;
        end else begin
            pv_q[0] <= w_accept;
            pd_q[0] <= w_resp_data;
            pe_q[0] <= w_resp_err;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 32'h0;
            wr_data_q   <= 32'h0;
        end else begin
            wr_strobe_q <= w_mem_wr;
            wr_addr_q   <= w_mem_wr ? data_if.data_addr : 32'h0;
            wr_data_q   <= w_mem_wr ? w_merged : 32'h0;
        end
    end

    assign data_if.data_gnt    = w_gnt & rst_ni;
    assign data_if.data_rvalid = w_rvalid;
    assign data_if.data_rdata  = pd_q[RESP_LATENCY-1];
    assign data_if.data_err    = pe_q[RESP_LATENCY-1];

    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_guvm_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_guvm_data_mem_responder
// Brief    : Two responders (latency 1 and 4) on shared stimulus, checked
//            every cycle against a transaction-level model.
// ============================================================================
module tb_guvm_data_mem_responder;

    localparam int MW    = 256;
    localparam int LAT_A = 1;
    localparam int LAT_B = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  stall;

    always #5 clk = ~clk;

    guvm_data_mem_responder_if bus_a ();
    guvm_data_mem_responder_if bus_b ();

    assign bus_a.data_req   = req;
    assign bus_a.data_addr  = addr;
    assign bus_a.data_we    = we;
    assign bus_a.data_be    = be;
    assign bus_a.data_wdata = wdata;
    assign bus_b.data_req   = req;
    assign bus_b.data_addr  = addr;
    assign bus_b.data_we    = we;
    assign bus_b.data_be    = be;
    assign bus_b.data_wdata = wdata;

    logic        ws_a, ws_b;
    logic [31:0] wa_a, wa_b, wd_a, wd_b;

    guvm_data_mem_responder #(.MEM_WORDS(MW), .RESP_LATENCY(LAT_A), .MAX_OUTSTANDING(MAXO)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .data_if(bus_a), .stall_cfg_i(stall),
        .wr_strobe_o(ws_a), .wr_addr_o(wa_a), .wr_data_o(wd_a));

    guvm_data_mem_responder #(.MEM_WORDS(MW), .RESP_LATENCY(LAT_B), .MAX_OUTSTANDING(MAXO)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .data_if(bus_b), .stall_cfg_i(stall),
        .wr_strobe_o(ws_b), .wr_addr_o(wa_b), .wr_data_o(wd_b));

    logic        o_gnt [2];
    logic        o_rv  [2];
    logic        o_err [2];
    logic        o_ws  [2];
    logic [31:0] o_rd  [2];
    logic [31:0] o_wa  [2];
    logic [31:0] o_wd  [2];

    always_comb begin
        o_gnt[0] = bus_a.data_gnt;    o_gnt[1] = bus_b.data_gnt;
        o_rv[0]  = bus_a.data_rvalid; o_rv[1]  = bus_b.data_rvalid;
        o_err[0] = bus_a.data_err;    o_err[1] = bus_b.data_err;
        o_rd[0]  = bus_a.data_rdata;  o_rd[1]  = bus_b.data_rdata;
        o_ws[0]  = ws_a;              o_ws[1]  = ws_b;
        o_wa[0]  = wa_a;              o_wa[1]  = wa_b;
        o_wd[0]  = wd_a;              o_wd[1]  = wd_b;
    end

    // ---------------- model state ----------------
    typedef struct packed {
        int          due;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] mask;
    } resp_t;

    resp_t       rq [2][$];
    int          waited    [2];
    int          stall_lat [2];
    logic [31:0] mem_m [2][MW];
    logic [3:0]  kn    [2][MW] = '{default: '0};
    logic        ew_v  [2];
    logic [31:0] ew_a  [2];
    logic [31:0] ew_d  [2];
    logic [31:0] ew_m  [2];
    int          cyc = 0;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic model_accept(input int d, input int lat);
        resp_t       r;
        int          w;
        logic [31:0] nw;
        w       = int'(addr[9:2]);
        r.due   = cyc + lat;
        r.rdata = 32'h0;
        r.err   = 1'b0;
        r.mask  = 32'hFFFF_FFFF;
        if (addr >= 32'(MW * 4)) begin
            r.err = 1'b1;
        end else if (we) begin
            nw = mem_m[d][w];
            for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wdata[8*b +: 8];
            mem_m[d][w] = nw;
            kn[d][w]    = kn[d][w] | be;
            ew_v[d] = 1'b1;
            ew_a[d] = addr;
            ew_d[d] = nw;
            ew_m[d] = lane_mask(kn[d][w]);
        end else begin
            r.rdata = mem_m[d][w];
            r.mask  = lane_mask(kn[d][w]);
        end
        rq[d].push_back(r);
    endtask

    task automatic model_step(input int d);
        int    lat;
        int    pend;
        logic  erv;
        logic  eg;
        resp_t fr;
        lat  = (d == 0) ? LAT_A : LAT_B;
        pend = 0;
        erv  = (rq[d].size() > 0) && (rq[d][0].due == cyc);
        for (int i = 0; i < rq[d].size(); i++) if (rq[d][i].due > cyc) pend++;
        chk($sformatf("rvalid[%0d]", d), {31'b0, o_rv[d]}, {31'b0, erv});
        if (erv) begin
            fr = rq[d].pop_front();
            chk($sformatf("rdata[%0d]", d), o_rd[d] & fr.mask, fr.rdata & fr.mask);
            chk($sformatf("err[%0d]", d), {31'b0, o_err[d]}, {31'b0, fr.err});
        end
        chk($sformatf("wr_strobe[%0d]", d), {31'b0, o_ws[d]}, {31'b0, ew_v[d]});
        if (ew_v[d]) begin
            chk($sformatf("wr_addr[%0d]", d), o_wa[d], ew_a[d]);
            chk($sformatf("wr_data[%0d]", d), o_wd[d] & ew_m[d], ew_d[d] & ew_m[d]);
        end
        ew_v[d] = 1'b0;
        if (!req) begin
            eg        = 1'b0;
            waited[d] = 0;
        end else begin
            if (waited[d] == 0) stall_lat[d] = int'(stall);
            eg = (waited[d] >= stall_lat[d]) && (pend < MAXO);
        end
        chk($sformatf("gnt[%0d]", d), {31'b0, o_gnt[d]}, {31'b0, eg});
        if (req && eg) begin
            model_accept(d, lat);
            waited[d] = 0;
        end else if (req) begin
            waited[d]++;
        end
    endtask

    // Single compare process: outputs are checked, then the model advances.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                chk($sformatf("rst_gnt[%0d]", d), {31'b0, o_gnt[d]}, 32'h0);
                chk($sformatf("rst_rvalid[%0d]", d), {31'b0, o_rv[d]}, 32'h0);
                chk($sformatf("rst_rdata[%0d]", d), o_rd[d], 32'h0);
                chk($sformatf("rst_err[%0d]", d), {31'b0, o_err[d]}, 32'h0);
                chk($sformatf("rst_wr_strobe[%0d]", d), {31'b0, o_ws[d]}, 32'h0);
                chk($sformatf("rst_wr_data[%0d]", d), o_wd[d], 32'h0);
                rq[d].delete();
                waited[d] = 0;
                ew_v[d]   = 1'b0;
            end else begin
                model_step(d);
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    function automatic logic gnt_of(input int sel);
        return (sel == 0) ? bus_a.data_gnt : bus_b.data_gnt;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) step();
    endtask

    // Issue one transaction at posedge+1; returns cycles waited for grant.
    task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] dat, input int sel, output int wc);
        req = 1'b1; we = w; addr = a; be = b; wdata = dat;
        wc = 0;
        forever begin
            @(negedge clk);
            if (gnt_of(sel)) break;
            wc++;
            if (wc > 40) begin
                n_cmp++;
                n_fail++;
                $display("FAIL txn_timeout: no grant after %0d cycles, expected grant", wc);
                break;
            end
            step();
        end
        step();
        req = 1'b0;
    endtask

    initial begin
        int wc;
        int cnt;
        int acc_n;
        int acc_cyc [3];
        int first_rv;
        int live;
        int max_live;
        int widx;
        logic acc;

        req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; stall = 4'd0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rvalid_a", {31'b0, bus_a.data_rvalid}, 32'h0);
        chk("reset_strobe_a", {31'b0, ws_a}, 32'h0);
        step();

        // Write then read back, no stall, latency 1
        txn(1'b1, 32'h100, 4'hF, 32'hCAFE_F00D, 0, wc);
        chk("wr100_gnt_wait", wc, 0);
        chk("model_mem_100", mem_m[0][64], 32'hCAFE_F00D);
        txn(1'b0, 32'h100, 4'hF, 32'h0, 0, wc);
        chk("rd100_gnt_wait", wc, 0);
        @(negedge clk);
        chk("rd100_rvalid", {31'b0, bus_a.data_rvalid}, 32'h1);
        chk("rd100_rdata", bus_a.data_rdata, 32'hCAFE_F00D);
        chk("rd100_err", {31'b0, bus_a.data_err}, 32'h0);
        step();

        // Partial byte-lane write
        idle(6);
        txn(1'b1, 32'h20, 4'hF, 32'h1122_3344, 0, wc);
        txn(1'b1, 32'h20, 4'b0010, 32'h0000_AB00, 0, wc);
        @(negedge clk);
        chk("pw_strobe", {31'b0, ws_a}, 32'h1);
        chk("pw_wr_addr", wa_a, 32'h20);
        chk("pw_wr_data", wd_a, 32'h1122_AB44);
        chk("model_mem_20", mem_m[0][8], 32'h1122_AB44);
        step();
        txn(1'b0, 32'h20, 4'hF, 32'h0, 0, wc);
        @(negedge clk);
        chk("pw_readback", bus_a.data_rdata, 32'h1122_AB44);
        step();

        // Grant stall of 3, then a request abandoned mid-stall
        idle(8);
        stall = 4'd3;
        txn(1'b0, 32'h100, 4'hF, 32'h0, 0, wc);
        chk("stall3_wait", wc, 3);
        idle(8);
        req = 1'b1; we = 1'b0; addr = 32'h100;
        step();
        step();
        req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_a.data_rvalid || bus_a.data_gnt) cnt++;
            step();
        end
        chk("abandoned_no_resp", cnt, 0);
        stall = 4'd0;

        // Latency 4 / limit 2 with continuous reads on distinct words
        idle(8);
        for (int i = 0; i < 4; i++) txn(1'b1, 32'(i * 4), 4'hF, 32'hA0A0_0000 + 32'(i), 1, wc);
        idle(8);
        acc_n = 0; first_rv = -1; live = 0; max_live = 0; widx = 0;
        req = 1'b1; we = 1'b0; addr = 32'h0;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            acc = bus_b.data_gnt;
            if (bus_b.data_rvalid) begin
                live--;
                if (first_rv < 0) first_rv = t;
            end
            if (acc) begin
                if (acc_n < 3) acc_cyc[acc_n] = t;
                acc_n++;
                live++;
                widx = (widx + 1) % 4;
            end
            if (live > max_live) max_live = live;
            step();
            addr = 32'(widx * 4);
        end
        req = 1'b0;
        chk("lat4_max_outstanding", max_live, MAXO);
        chk("lat4_first_rv", first_rv, LAT_B);
        chk("lat4_third_acc_on_rv", acc_cyc[2], first_rv);

        // Out-of-range read
        idle(8);
        txn(1'b0, 32'h0000_0400, 4'hF, 32'h0, 0, wc);
        @(negedge clk);
        chk("oor_rvalid", {31'b0, bus_a.data_rvalid}, 32'h1);
        chk("oor_err", {31'b0, bus_a.data_err}, 32'h1);
        chk("oor_rdata", bus_a.data_rdata, 32'h0);
        step();

        // Reset with two responses in flight on the latency-4 responder
        idle(8);
        txn(1'b0, 32'h100, 4'hF, 32'h0, 1, wc);
        txn(1'b0, 32'h104, 4'hF, 32'h0, 1, wc);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_b.data_rvalid) cnt++;
            step();
        end
        chk("rst_flush_no_rvalid", cnt, 0);
        txn(1'b0, 32'h100, 4'hF, 32'h0, 1, wc);
        chk("post_rst_gnt_wait", wc, 0);

        // Randomized traffic
        idle(8);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            acc = req & bus_a.data_gnt;
            step();
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            if ($urandom_range(0, 9) == 0) stall = 4'($urandom_range(0, 4));
            if (!req || acc || $urandom_range(0, 15) == 0) begin
                req   = ($urandom_range(0, 3) != 0);
                we    = 1'($urandom_range(0, 1));
                be    = 4'($urandom);
                wdata = $urandom;
                case ($urandom_range(0, 9))
                    0:       addr = 32'h400 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
                    1:       addr = $urandom;
                    default: addr = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                endcase
            end
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
